// File: rtl/lcd_init_seq.sv
// rtl/lcd_init_seq.sv - HD44780-style LCD power-up/init sequencer with user word pass-through
module lcd_init_seq #(
  parameter int POWERUP_CYCLES   = 1500000,
  parameter int CMD_WAIT_CYCLES  = 4000,
  parameter int LONG_WAIT_CYCLES = 164000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [8:0] usr_data,
  input  logic       usr_valid,
  output logic       usr_ready,
  input  logic       reinit,
  output logic       init_done,
  output logic [8:0] ctrl_data,
  output logic       ctrl_valid,
  input  logic       ctrl_ready
);

  typedef enum logic [2:0] {
    S_POWERUP,
    S_INIT_SEND,
    S_INIT_WAIT,
    S_IDLE,
    S_USR_SEND,
    S_USR_WAIT
  } state_e;

  localparam logic [23:0] PU_LOAD   = 24'(POWERUP_CYCLES);
  localparam logic [23:0] CMD_LOAD  = 24'(CMD_WAIT_CYCLES);
  localparam logic [23:0] LONG_LOAD = 24'(LONG_WAIT_CYCLES);

  state_e      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [8:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;

  logic        xfer;
  logic        long_cmd;
  logic        cnt_last;
  logic [1:0]  idx_nxt;
  logic [23:0] wait_load;

  // Init command ROM: function set, display on, clear, entry mode.
  function automatic logic [8:0] init_rom(input logic [1:0] i);
    case (i)
      2'd0:    init_rom = 9'h038;
      2'd1:    init_rom = 9'h00C;
      2'd2:    init_rom = 9'h001;
      default: init_rom = 9'h006;
    endcase
  endfunction

  assign xfer      = valid_q & ctrl_ready;
  // Clear (0x001) and return-home (0x002/0x003) need the long settle time.
  assign long_cmd  = (data_q[8:2] == 7'd0) && (data_q[1:0] != 2'd0);
  assign wait_load = long_cmd ? LONG_LOAD : CMD_LOAD;
  assign cnt_last  = (cnt_q == 24'd1);
  assign idx_nxt   = idx_q + 2'd1;

  assign usr_ready  = (state_q == S_IDLE) && !reinit;
  assign init_done  = done_q;
  assign ctrl_data  = data_q;
  assign ctrl_valid = valid_q;

  // Next-state logic: counters reload on entry to a timed state and step down to 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    valid_d = valid_q;
    done_d  = done_q;
    case (state_q)
      S_POWERUP: begin
        if (cnt_last) begin
          state_d = S_INIT_SEND;
          idx_d   = 2'd0;
          data_d  = init_rom(2'd0);
          valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end
      S_INIT_SEND: begin
        if (xfer) begin
          valid_d = 1'b0;
          cnt_d   = wait_load;
          state_d = S_INIT_WAIT;
        end
      end
      S_INIT_WAIT: begin
        if (cnt_last) begin
          if (idx_q == 2'd3) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_nxt;
            data_d  = init_rom(idx_nxt);
            valid_d = 1'b1;
            state_d = S_INIT_SEND;
          end
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end
      S_IDLE: begin
        if (reinit) begin
          state_d = S_POWERUP;
          cnt_d   = PU_LOAD;
          idx_d   = 2'd0;
          done_d  = 1'b0;
        end else if (usr_valid) begin
          data_d  = usr_data;
          valid_d = 1'b1;
          state_d = S_USR_SEND;
        end
      end
      S_USR_SEND: begin
        if (xfer) begin
          valid_d = 1'b0;
          cnt_d   = wait_load;
          state_d = S_USR_WAIT;
        end
      end
      S_USR_WAIT: begin
        if (cnt_last) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end
      default: begin
        state_d = S_POWERUP;
        cnt_d   = PU_LOAD;
        idx_d   = 2'd0;
        valid_d = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // State register; reset aborts any transfer or wait immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_POWERUP;
      cnt_q   <= PU_LOAD;
      idx_q   <= 2'd0;
      data_q  <= 9'h000;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_lcd_init_seq.sv
// tb/tb_lcd_init_seq.sv - self-checking bench for lcd_init_seq against a behavioural model
module tb_lcd_init_seq;

  localparam int PU = 20;
  localparam int CW = 4;
  localparam int LW = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [8:0] usr_data = 9'h000;
  logic       usr_valid = 1'b0;
  logic       reinit = 1'b0;
  logic       ctrl_ready = 1'b1;
  logic       usr_ready;
  logic       init_done;
  logic [8:0] ctrl_data;
  logic       ctrl_valid;

  always #5 clk = ~clk;

  lcd_init_seq #(
    .POWERUP_CYCLES(PU),
    .CMD_WAIT_CYCLES(CW),
    .LONG_WAIT_CYCLES(LW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .usr_data(usr_data),
    .usr_valid(usr_valid),
    .usr_ready(usr_ready),
    .reinit(reinit),
    .init_done(init_done),
    .ctrl_data(ctrl_data),
    .ctrl_valid(ctrl_valid),
    .ctrl_ready(ctrl_ready)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Behavioural model: a blocking timer, a queue of words still to send,
  // the word currently offered, and whether init has completed.
  int         m_block;
  logic [8:0] m_q[$];
  bit         m_has;
  logic [8:0] m_word;
  bit         m_done;

  function automatic int wait_len(input logic [8:0] w);
    return (w[8:2] == 7'd0 && w[1:0] != 2'd0) ? LW : CW;
  endfunction

  function automatic void model_reset();
    m_block = PU;
    m_q = '{9'h038, 9'h00C, 9'h001, 9'h006};
    m_has = 1'b0;
    m_word = 9'h000;
    m_done = 1'b0;
  endfunction

  function automatic bit m_idle();
    return m_done && !m_has && m_block == 0;
  endfunction

  initial model_reset();

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      model_reset();
    end else if (m_has) begin
      if (ctrl_ready) begin
        m_has = 1'b0;
        m_block = wait_len(m_word);
      end
    end else if (m_block > 0) begin
      m_block--;
      if (m_block == 0) begin
        if (m_q.size() > 0) begin
          m_word = m_q.pop_front();
          m_has = 1'b1;
        end else begin
          m_done = 1'b1;
        end
      end
    end else if (reinit) begin
      model_reset();
    end else if (usr_valid) begin
      m_has = 1'b1;
      m_word = usr_data;
    end
  end

  // Transfer log: word and the edge number at which it completes.
  logic [8:0] xw[$];
  int         xc[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_ctrl_valid", 32'(ctrl_valid), 32'd0);
      check("rst_ctrl_data", 32'(ctrl_data), 32'd0);
      check("rst_usr_ready", 32'(usr_ready), 32'd0);
      check("rst_init_done", 32'(init_done), 32'd0);
    end else begin
      check("ctrl_valid", 32'(ctrl_valid), 32'(m_has));
      if (m_has) check("ctrl_data", 32'(ctrl_data), 32'(m_word));
      check("usr_ready", 32'(usr_ready), 32'(m_idle() && !reinit));
      check("init_done", 32'(init_done), 32'(m_done));
      if (ctrl_valid && ctrl_ready) begin
        xw.push_back(ctrl_data);
        xc.push_back(cyc + 1);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input int bound);
    int i = 0;
    while (!init_done && i < bound) begin
      tick(1);
      i++;
    end
    check("init_done_timeout", 32'(init_done), 32'd1);
  endtask

  task automatic wait_usr_ready(input int bound);
    int i = 0;
    while (!usr_ready && i < bound) begin
      tick(1);
      i++;
    end
    check("usr_ready_timeout", 32'(usr_ready), 32'd1);
  endtask

  // Full init with ctrl_ready held high, timed from reference edge r.
  task automatic check_init(input int base, input int r);
    check("init_count", 32'(xw.size() - base), 32'd4);
    check("init_w0", 32'(xw[base]),     32'h038);
    check("init_w1", 32'(xw[base + 1]), 32'h00C);
    check("init_w2", 32'(xw[base + 2]), 32'h001);
    check("init_w3", 32'(xw[base + 3]), 32'h006);
    check("init_t0", 32'(xc[base] - r),     32'd21);
    check("init_t1", 32'(xc[base + 1] - r), 32'd26);
    check("init_t2", 32'(xc[base + 2] - r), 32'd31);
    check("init_t3", 32'(xc[base + 3] - r), 32'd42);
    check("init_done_t", 32'(cyc - r), 32'd46);
    check("init_usr_ready", 32'(usr_ready), 32'd1);
  endtask

  initial begin
    int rel;
    int base;
    int t;
    int i;

    // Reset, release, full init.
    tick(3);
    rst_n = 1'b1;
    rel = cyc;
    base = xw.size();
    wait_done(200);
    check_init(base, rel);

    // Stall on 0x00C for 7 cycles.
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    rel = cyc;
    base = xw.size();
    i = 0;
    while (!(ctrl_valid && ctrl_data == 9'h00C) && i < 100) begin
      tick(1);
      i++;
    end
    check("stall_reach", 32'(ctrl_data), 32'h00C);
    ctrl_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      tick(1);
      check("stall_valid", 32'(ctrl_valid), 32'd1);
      check("stall_data", 32'(ctrl_data), 32'h00C);
    end
    ctrl_ready = 1'b1;
    wait_done(200);
    check("stall_t1", 32'(xc[base + 1] - rel), 32'd33);
    check("stall_t2", 32'(xc[base + 2] - rel), 32'd38);
    check("stall_t3", 32'(xc[base + 3] - rel), 32'd49);
    check("stall_done_t", 32'(cyc - rel), 32'd53);

    // User words: short and long waits.
    usr_data = 9'h141;
    usr_valid = 1'b1;
    tick(1);
    usr_valid = 1'b0;
    check("usr_busy", 32'(usr_ready), 32'd0);
    check("usr_valid_out", 32'(ctrl_valid), 32'd1);
    check("usr_data_out", 32'(ctrl_data), 32'h141);
    base = xw.size();
    wait_usr_ready(50);
    check("usr_word", 32'(xw[base]), 32'h141);
    check("usr_gap_short", 32'(cyc - xc[base]), 32'd4);

    usr_data = 9'h001;
    usr_valid = 1'b1;
    tick(1);
    usr_valid = 1'b0;
    base = xw.size();
    wait_usr_ready(50);
    check("usr_word_clr", 32'(xw[base]), 32'h001);
    check("usr_gap_long", 32'(cyc - xc[base]), 32'd10);

    // Reinit collides with a user word.
    reinit = 1'b1;
    usr_valid = 1'b1;
    usr_data = 9'h0AB;
    #1;
    check("reinit_usr_ready", 32'(usr_ready), 32'd0);
    tick(1);
    t = cyc;
    reinit = 1'b0;
    usr_valid = 1'b0;
    check("reinit_done_clr", 32'(init_done), 32'd0);
    check("reinit_no_valid", 32'(ctrl_valid), 32'd0);
    base = xw.size();
    wait_done(200);
    check_init(base, t);

    // Reset during a user wait.
    usr_data = 9'h155;
    usr_valid = 1'b1;
    tick(1);
    usr_valid = 1'b0;
    tick(3);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(ctrl_valid), 32'd0);
    check("midrst_done", 32'(init_done), 32'd0);
    tick(2);
    rst_n = 1'b1;
    rel = cyc;
    base = xw.size();
    wait_done(200);
    check_init(base, rel);

    // Randomised traffic checked cycle by cycle against the model.
    for (int k = 0; k < 3000; k++) begin
      ctrl_ready = ($urandom_range(0, 3) != 0);
      usr_valid = 1'($urandom_range(0, 1));
      usr_data = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 3)) : 9'($urandom_range(0, 511));
      reinit = ($urandom_range(0, 49) == 0);
      rst_n = ($urandom_range(0, 999) != 0);
      tick(1);
    end
    rst_n = 1'b1;
    reinit = 1'b0;
    usr_valid = 1'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lcd_init_seq.md
LCD_INIT_SEQ -- requirements
Module: lcd_init_seq

Interface
REQ-001 SHALL have parameter POWERUP_CYCLES, default 1500000: clk cycles waited after reset release before the first command.
REQ-002 SHALL have parameter CMD_WAIT_CYCLES, default 4000: idle cycles after each short command or data write.
REQ-003 SHALL have parameter LONG_WAIT_CYCLES, default 164000: idle cycles after clear or return-home commands.
REQ-004 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port usr_data  input  9  user word: bit 8 = RS (1 data, 0 command), bits 7:0 = LCD byte.
REQ-007 SHALL have port usr_valid  input  1  user word present.
REQ-008 SHALL have port usr_ready  output  1  sequencer can take a user word this cycle.
REQ-009 SHALL have port reinit  input  1  request to rerun power-up and init sequence.
REQ-010 SHALL have port init_done  output  1  init sequence complete; user path open.
REQ-011 SHALL have port ctrl_data  output  9  word to LCD controller data input (same RS/byte packing).
REQ-012 SHALL have port ctrl_valid  output  1  ctrl_data valid toward LCD controller.
REQ-013 SHALL have port ctrl_ready  input  1  LCD controller ready to accept a word.

Function
REQ-014 SHALL implement states POWERUP, INIT_SEND, INIT_WAIT, IDLE, USR_SEND, USR_WAIT.
REQ-015 SHALL count POWERUP_CYCLES cycles in POWERUP, then enter INIT_SEND with init index 0.
REQ-016 SHALL issue init ROM in order: 0x038 (8-bit, 2-line), 0x00C (display on), 0x001 (clear), 0x006 (entry mode inc).
REQ-017 SHALL treat a transfer to the LCD controller as complete at a rising edge where ctrl_valid=1 and ctrl_ready=1.
REQ-018 SHALL hold ctrl_data stable and ctrl_valid high from assertion until transfer; ctrl_ready low stalls indefinitely.
REQ-019 SHALL deassert ctrl_valid on the edge after transfer and enter INIT_WAIT or USR_WAIT.
REQ-020 SHALL select LONG_WAIT_CYCLES when the transferred word has bit 8=0, bits 7:2=0 and bits 1:0 nonzero (0x001-0x003); otherwise CMD_WAIT_CYCLES.
REQ-021 SHALL spend exactly the selected number of cycles in a WAIT state, counted from the edge after transfer, before ctrl_valid or usr_ready next asserts.
REQ-022 SHALL leave INIT_WAIT to INIT_SEND with next index, or to IDLE with init_done=1 after index 3.
REQ-023 SHALL drive usr_ready = (state==IDLE) and not reinit; usr_ready low in all other states.
REQ-024 SHALL accept a user word when usr_valid=1 and usr_ready=1 at a rising edge: register it into ctrl_data, set ctrl_valid=1 next cycle, enter USR_SEND.
REQ-025 SHALL pass user words unmodified, one at a time; no buffering beyond ctrl_data.
REQ-026 SHALL, when reinit=1 in IDLE, clear init_done, drop user word if present, and enter POWERUP with counter reloaded; reinit ignored in all other states.
REQ-027 SHALL use a 24-bit down-counter; all three parameters SHALL be 1 to 2^24-1.

Reset
REQ-028 SHALL, while rst_n=0, force state POWERUP, counter=POWERUP_CYCLES, init index 0, ctrl_data=0x000, ctrl_valid=0, usr_ready=0, init_done=0.
REQ-029 SHALL on reset assertion mid-operation abort at once, no completion of pending transfer or wait, and restart from POWERUP on release.

Verification (POWERUP=20, CMD_WAIT=4, LONG_WAIT=10)
REQ-030 SHALL verify: reset then release with ctrl_ready=1 -> all outputs 0 for 20 cycles, then ctrl_valid=1, ctrl_data=0x038.
REQ-031 SHALL verify: full init, ctrl_ready=1 -> words 0x038,0x00C,0x001,0x006 in order; gap 10 cycles after 0x001, 4 after others; init_done=1 and usr_ready=1 after last gap.
REQ-032 SHALL verify: ctrl_ready held 0 for 7 cycles during 0x00C -> ctrl_data stays 0x00C, ctrl_valid stays 1, wait starts only after transfer.
REQ-033 SHALL verify: usr_data=0x141, usr_valid=1 in IDLE -> usr_ready drops, ctrl_data=0x141 transferred, usr_ready returns 4 cycles after transfer; usr_data=0x001 -> 10 cycles.
REQ-034 SHALL verify: reinit=1 and usr_valid=1 same cycle in IDLE -> usr_ready=0, no ctrl_valid for user word, init_done=0, 20-cycle power-up then 0x038.
REQ-035 SHALL verify: rst_n pulsed low during USR_WAIT -> ctrl_valid=0, init_done=0 immediately; full init sequence repeats after release.
